// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared encodings and widths for the FIFO write-port arbiter
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int STATS_W     = 16;
    localparam int BURST_CNT_W = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - rotating priority encoder, scan starts just after start index
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int j;
        j     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        // start itself is visited last (k == N wraps back to it)
        for (int k = 1; k <= N; k++) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared FIFO write port
// Optional per-requester accept counters: FIFO_WR_ARBITER_STATS_EN
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int B         = 8,
    parameter int MAX_BURST = 4,
    parameter int IW        = $clog2(N)
) (
    input  logic             clk,
    input  logic             rstn_i,
    input  logic [N-1:0]     req_i,
    input  logic [N*B-1:0]   data_i,
    output logic [N-1:0]     gnt_o,
    input  logic             fifo_full_i,
    output logic             fifo_wr_o,
    output logic [B-1:0]     fifo_wdata_o,
    output logic [IW-1:0]    owner_o,
`ifdef FIFO_WR_ARBITER_STATS_EN
    input  logic             stats_clr_i,
    output logic [N*STATS_W-1:0] stats_o,
`endif
    output logic             busy_o
);

    localparam logic [IW-1:0]          OWNER_RST = IW'(N - 1);
    localparam logic [BURST_CNT_W-1:0] MAX_CNT   = BURST_CNT_W'(MAX_BURST);

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [BURST_CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;
    logic          keep_owner;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req   (req_i),
        .start (owner_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign keep_owner = (state_q == ST_BURST) && req_i[owner_q] && (cnt_q < MAX_CNT);

    always_comb begin
        gnt_o   = '0;
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        // a full FIFO freezes everything so the pointer and burst resume untouched
        if (rstn_i && !fifo_full_i) begin
            if (keep_owner) begin
                gnt_o[owner_q] = 1'b1;
                cnt_d          = cnt_q + 1'b1;
            end else if (pick_valid) begin
                gnt_o   = pick_gnt;
                owner_d = pick_idx;
                cnt_d   = BURST_CNT_W'(1);
                state_d = ST_BURST;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        fifo_wdata_o = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_o[i]) fifo_wdata_o = fifo_wdata_o | data_i[i*B +: B];
        end
    end

    assign fifo_wr_o = |gnt_o;
    assign owner_o   = owner_q;
    assign busy_o    = rstn_i && (state_q == ST_BURST);

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [STATS_W-1:0] stat_q [N];

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < N; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (stats_clr_i) begin
                    stat_q[i] <= '0;
                end else if (gnt_o[i] && (stat_q[i] != '1)) begin
                    stat_q[i] <= stat_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stats_o = '0;
        for (int i = 0; i < N; i++) stats_o[i*STATS_W +: STATS_W] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed table-driven bench for fifo_wr_arbiter with a depth-16 FIFO model
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic [3:0]  req_i;
    logic [31:0] data_i;
    logic [3:0]  gnt_o;
    logic        fifo_full_i;
    logic        fifo_wr_o;
    logic [7:0]  fifo_wdata_o;
    logic [1:0]  owner_o;
    logic        busy_o;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic        stats_clr_i;
    logic [63:0] stats_o;
`endif

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N(4), .B(8), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rstn_i       (rstn_i),
        .req_i        (req_i),
        .data_i       (data_i),
        .gnt_o        (gnt_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_wr_o    (fifo_wr_o),
        .fifo_wdata_o (fifo_wdata_o),
        .owner_o      (owner_o),
`ifdef FIFO_WR_ARBITER_STATS_EN
        .stats_clr_i  (stats_clr_i),
        .stats_o      (stats_o),
`endif
        .busy_o       (busy_o)
    );

    // FIFO write-side model: occupancy counter plus a log of accepted words
    int         fcnt = 0;
    logic       rd;
    logic       fifo_clr;
    logic       full_force;
    logic [7:0] wlog [$];

    always @(posedge clk) begin
        if (fifo_clr) begin
            fcnt <= 0;
            wlog.delete();
        end else begin
            if (fifo_wr_o) wlog.push_back(fifo_wdata_o);
            fcnt <= fcnt + (fifo_wr_o ? 1 : 0) - (rd ? 1 : 0);
        end
    end

    assign fifo_full_i = full_force || (fcnt >= 16);

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic        full;
        logic [3:0]  e_gnt;
        logic [7:0]  e_wdata;
        logic [1:0]  e_owner;
        logic        e_busy;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] D = 32'h30201000;
    localparam logic [7:0]  BURST_EXP [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2};

    initial begin
        vt[0]  = '{4'b0001, 32'h000000A0, 1'b0, 4'b0001, 8'hA0, 2'd0, 1'b1};
        vt[1]  = '{4'b0001, 32'h000000A0, 1'b0, 4'b0001, 8'hA0, 2'd0, 1'b1};
        vt[2]  = '{4'b0001, 32'h000000A0, 1'b0, 4'b0001, 8'hA0, 2'd0, 1'b1};
        vt[3]  = '{4'b0000, 32'h000000A0, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0};
        vt[4]  = '{4'b0110, D,            1'b1, 4'b0000, 8'h00, 2'd0, 1'b0};
        vt[5]  = '{4'b0110, D,            1'b0, 4'b0010, 8'h10, 2'd1, 1'b1};
        vt[6]  = '{4'b0100, D,            1'b0, 4'b0100, 8'h20, 2'd2, 1'b1};
        vt[7]  = '{4'b1100, D,            1'b0, 4'b0100, 8'h20, 2'd2, 1'b1};
        vt[8]  = '{4'b1000, D,            1'b0, 4'b1000, 8'h30, 2'd3, 1'b1};
        vt[9]  = '{4'b1000, D,            1'b1, 4'b0000, 8'h00, 2'd3, 1'b1};
        vt[10] = '{4'b0000, D,            1'b0, 4'b0000, 8'h00, 2'd3, 1'b0};

        rstn_i     = 1'b0;
        req_i      = 4'b1111;
        data_i     = D | 32'h0F0F0F0F;
        full_force = 1'b0;
        rd         = 1'b0;
        fifo_clr   = 1'b1;
`ifdef FIFO_WR_ARBITER_STATS_EN
        stats_clr_i = 1'b0;
`endif
        repeat (2) tick();
        chk("rst_gnt",   gnt_o, 4'b0000);
        chk("rst_wr",    fifo_wr_o, 1'b0);
        chk("rst_wdata", fifo_wdata_o, 8'h00);
        chk("rst_owner", owner_o, 2'd3);
        chk("rst_busy",  busy_o, 1'b0);
`ifdef FIFO_WR_ARBITER_STATS_EN
        chk("rst_stats", stats_o, 64'h0);
`endif
        rstn_i = 1'b1;
        req_i  = 4'b0000;

        for (int i = 0; i < 11; i++) begin
            req_i      = vt[i].req;
            data_i     = vt[i].data;
            full_force = vt[i].full;
            #1;
            chk($sformatf("v%0d_gnt", i),   gnt_o, vt[i].e_gnt);
            chk($sformatf("v%0d_wr", i),    fifo_wr_o, |vt[i].e_gnt);
            chk($sformatf("v%0d_wdata", i), fifo_wdata_o, vt[i].e_wdata);
            tick();
            chk($sformatf("v%0d_owner", i), owner_o, vt[i].e_owner);
            chk($sformatf("v%0d_busy", i),  busy_o, vt[i].e_busy);
        end
        full_force = 1'b0;

        // lone requester 1: burst of 4, forced rotation re-grants it
        req_i  = 4'b0010;
        data_i = D;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("solo%0d_gnt", k), gnt_o, 4'b0010);
            tick();
            chk($sformatf("solo%0d_cnt", k), dut.cnt_q, BURST_EXP[k]);
            chk($sformatf("solo%0d_owner", k), owner_o, 2'd1);
        end

        // async reset mid-burst
        rstn_i = 1'b0;
        #1;
        chk("arst_gnt",   gnt_o, 4'b0000);
        chk("arst_wr",    fifo_wr_o, 1'b0);
        chk("arst_busy",  busy_o, 1'b0);
        chk("arst_owner", owner_o, 2'd3);
        tick();
        rstn_i   = 1'b1;
        fifo_clr = 1'b0;
        req_i    = 4'b1111;
        data_i   = D;

        for (int k = 0; k < 16; k++) begin
            #1;
            chk($sformatf("fill%0d_gnt", k), gnt_o, 4'b0001 << (k / 4));
            tick();
        end
        chk("fill_count", wlog.size(), 16);
        for (int k = 0; k < 16 && k < wlog.size(); k++) begin
            chk($sformatf("fill%0d_word", k), wlog[k], 8'(8'h10 * (k / 4)));
        end
        chk("full_flag", fifo_full_i, 1'b1);
        chk("full_gnt",  gnt_o, 4'b0000);
        chk("full_wr",   fifo_wr_o, 1'b0);
`ifdef FIFO_WR_ARBITER_STATS_EN
        chk("fill_stats", stats_o, {16'd4, 16'd4, 16'd4, 16'd4});
`endif

        req_i = 4'b0110;
        #1;
        chk("full2_gnt", gnt_o, 4'b0000);
        chk("full2_wr",  fifo_wr_o, 1'b0);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        #1;
        chk("drain_gnt",   gnt_o, 4'b0010);
        chk("drain_wr",    fifo_wr_o, 1'b1);
        chk("drain_wdata", fifo_wdata_o, 8'h10);
        tick();
        chk("refull_gnt", gnt_o, 4'b0000);
        chk("one_write",  wlog.size(), 17);
        if (wlog.size() == 17) chk("last_word", wlog[16], 8'h10);

`ifdef FIFO_WR_ARBITER_STATS_EN
        chk("pre_clr_stats", stats_o, {16'd4, 16'd4, 16'd5, 16'd4});
        stats_clr_i = 1'b1;
        tick();
        stats_clr_i = 1'b0;
        chk("clr_stats", stats_o, 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
